// File: rtl/dm_sba_ctrl.sv
// dm_sba_ctrl: system bus access master for the debug module.
// Takes address/data triggers from the debug registers, issues one host
// bus access at a time and reports read data or an error code back.
//
// state   | meaning
// IDLE    | waiting for an address/data trigger
// RD_REQ  | read request presented on host bus, awaiting grant
// WR_REQ  | write request presented on host bus, awaiting grant
// RD_WAIT | read granted, awaiting response
// WR_WAIT | write granted, awaiting response
module dm_sba_ctrl #(
  parameter int BusWidth      = 32,
  parameter int TimeoutCycles = 256
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  dmactive_i,
  input  logic [BusWidth-1:0]   sbaddress_i,
  input  logic                  sbaddress_write_valid_i,
  input  logic                  sbreadonaddr_i,
  input  logic                  sbautoincrement_i,
  input  logic                  sbreadondata_i,
  input  logic [2:0]            sbaccess_i,
  input  logic [BusWidth-1:0]   sbdata_i,
  input  logic                  sbdata_write_valid_i,
  input  logic                  sbdata_read_valid_i,
  output logic [BusWidth-1:0]   sbdata_o,
  output logic                  sbdata_valid_o,
  output logic [BusWidth-1:0]   sbaddress_o,
  output logic                  sbbusy_o,
  output logic                  sberror_valid_o,
  output logic [2:0]            sberror_o,
  output logic                  host_req_o,
  output logic [BusWidth-1:0]   host_add_o,
  output logic                  host_we_o,
  output logic [BusWidth-1:0]   host_wdata_o,
  output logic [BusWidth/8-1:0] host_be_o,
  input  logic                  host_gnt_i,
  input  logic                  host_r_valid_i,
  input  logic [BusWidth-1:0]   host_r_rdata_i,
  input  logic                  host_err_i
);

  localparam int BeW  = BusWidth / 8;
  localparam int OffW = $clog2(BeW);
  localparam int TmrW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
  localparam logic [TmrW-1:0] TmrLoad = TmrW'((TimeoutCycles > 0) ? TimeoutCycles - 1 : 0);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] RD_REQ  = 3'd1;
  localparam logic [2:0] WR_REQ  = 3'd2;
  localparam logic [2:0] RD_WAIT = 3'd3;
  localparam logic [2:0] WR_WAIT = 3'd4;

  localparam logic [2:0] ERR_TIMEOUT = 3'd1;
  localparam logic [2:0] ERR_BUS     = 3'd2;
  localparam logic [2:0] ERR_ALIGN   = 3'd3;
  localparam logic [2:0] ERR_SIZE    = 3'd4;

  logic [2:0]          state_q, state_d;
  logic [BusWidth-1:0] addr_q, addr_d;
  logic [TmrW-1:0]     tmr_q, tmr_d;
  logic [3:0]          bytes_q, bytes_d;
  logic                host_req_q, host_req_d;
  logic [BusWidth-1:0] host_add_q, host_add_d;
  logic                host_we_q, host_we_d;
  logic [BusWidth-1:0] host_wdata_q, host_wdata_d;
  logic [BeW-1:0]      host_be_q, host_be_d;
  logic [BusWidth-1:0] sbdata_q, sbdata_d;
  logic                sbdata_valid_q, sbdata_valid_d;
  logic                err_valid_q, err_valid_d;
  logic [2:0]          err_q, err_d;

  logic [BusWidth-1:0] eff_addr;
  logic [OffW-1:0]     req_off;
  logic [3:0]          acc_bytes;
  logic                wr_trig, rd_trig, size_bad, misaligned;
  logic [BeW-1:0]      be_base;
  logic [BusWidth-1:0] rd_mask;

  // Trigger decode and lane/size arithmetic for a new access (uses the
  // address being loaded this cycle if there is one).
  always_comb begin
    eff_addr   = sbaddress_write_valid_i ? sbaddress_i : addr_q;
    req_off    = eff_addr[OffW-1:0];
    acc_bytes  = 4'd1 << sbaccess_i;
    wr_trig    = sbdata_write_valid_i;
    rd_trig    = (sbaddress_write_valid_i & sbreadonaddr_i) |
                 (sbdata_read_valid_i & sbreadondata_i);
    size_bad   = sbaccess_i > 3'(OffW);
    misaligned = |(eff_addr & ~({BusWidth{1'b1}} << sbaccess_i));
    be_base    = ~({BeW{1'b1}} << acc_bytes);
    rd_mask    = ~({BusWidth{1'b1}} << {bytes_q, 3'b000});
  end

  // Access sequencing: trigger, request/grant with timeout, response.
  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    tmr_d          = tmr_q;
    bytes_d        = bytes_q;
    host_req_d     = host_req_q;
    host_add_d     = host_add_q;
    host_we_d      = host_we_q;
    host_wdata_d   = host_wdata_q;
    host_be_d      = host_be_q;
    sbdata_d       = sbdata_q;
    sbdata_valid_d = 1'b0;
    err_valid_d    = 1'b0;
    err_d          = err_q;

    case (state_q)
      IDLE: begin
        if (dmactive_i) begin
          if (sbaddress_write_valid_i) addr_d = sbaddress_i;
          if (wr_trig || rd_trig) begin
            if (size_bad) begin
              err_valid_d = 1'b1;
              err_d       = ERR_SIZE;
            end else if (misaligned) begin
              err_valid_d = 1'b1;
              err_d       = ERR_ALIGN;
            end else begin
              state_d      = wr_trig ? WR_REQ : RD_REQ;
              host_req_d   = 1'b1;
              host_add_d   = eff_addr & {{(BusWidth-OffW){1'b1}}, {OffW{1'b0}}};
              host_we_d    = wr_trig;
              host_wdata_d = sbdata_i << {req_off, 3'b000};
              host_be_d    = be_base << req_off;
              bytes_d      = acc_bytes;
              tmr_d        = TmrLoad;
            end
          end
        end
      end
      RD_REQ, WR_REQ: begin
        if (!dmactive_i) begin
          state_d    = IDLE;
          host_req_d = 1'b0;
        end else if (host_gnt_i) begin
          state_d    = (state_q == RD_REQ) ? RD_WAIT : WR_WAIT;
          host_req_d = 1'b0;
        end else if (TimeoutCycles != 0 && tmr_q == '0) begin
          state_d     = IDLE;
          host_req_d  = 1'b0;
          err_valid_d = 1'b1;
          err_d       = ERR_TIMEOUT;
        end else if (tmr_q != '0) begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      RD_WAIT, WR_WAIT: begin
        if (host_r_valid_i) begin
          state_d = IDLE;
          // With the debug module inactive the response is simply dropped.
          if (dmactive_i) begin
            if (host_err_i) begin
              err_valid_d = 1'b1;
              err_d       = ERR_BUS;
            end else begin
              if (state_q == RD_WAIT) begin
                sbdata_d       = (host_r_rdata_i >> {addr_q[OffW-1:0], 3'b000}) & rd_mask;
                sbdata_valid_d = 1'b1;
              end
              if (sbautoincrement_i) addr_d = addr_q + BusWidth'(bytes_q);
            end
          end
        end
      end
      default: begin
        state_d    = IDLE;
        host_req_d = 1'b0;
      end
    endcase

    if (!dmactive_i) addr_d = '0;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= IDLE;
      addr_q         <= '0;
      tmr_q          <= '0;
      bytes_q        <= '0;
      host_req_q     <= 1'b0;
      host_add_q     <= '0;
      host_we_q      <= 1'b0;
      host_wdata_q   <= '0;
      host_be_q      <= '0;
      sbdata_q       <= '0;
      sbdata_valid_q <= 1'b0;
      err_valid_q    <= 1'b0;
      err_q          <= '0;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      tmr_q          <= tmr_d;
      bytes_q        <= bytes_d;
      host_req_q     <= host_req_d;
      host_add_q     <= host_add_d;
      host_we_q      <= host_we_d;
      host_wdata_q   <= host_wdata_d;
      host_be_q      <= host_be_d;
      sbdata_q       <= sbdata_d;
      sbdata_valid_q <= sbdata_valid_d;
      err_valid_q    <= err_valid_d;
      err_q          <= err_d;
    end
  end

  assign sbdata_o        = sbdata_q;
  assign sbdata_valid_o  = sbdata_valid_q;
  assign sbaddress_o     = addr_q;
  assign sbbusy_o        = (state_q != IDLE);
  assign sberror_valid_o = err_valid_q;
  assign sberror_o       = err_q;
  assign host_req_o      = host_req_q;
  assign host_add_o      = host_add_q;
  assign host_we_o       = host_we_q;
  assign host_wdata_o    = host_wdata_q;
  assign host_be_o       = host_be_q;

endmodule
